// File: rtl/fir_par_pkg.sv
// fir_par_pkg: default sizes, accumulator width and Q1.(NB-1) saturation bounds for fir_par
package fir_par_pkg;
  localparam int NB_DEF = 14;
  localparam int N_DEF = 10;
  localparam int J_DEF = 3;
  function automatic int acc_width(input int nb, input int n);
    return 2 * nb + $clog2(n + 1);
  endfunction
  function automatic longint sat_max(input int nb);
    return (64'sd1 <<< (nb - 1)) - 64'sd1;
  endfunction
  function automatic longint sat_min(input int nb);
    return -(64'sd1 <<< (nb - 1));
  endfunction
endpackage

// File: rtl/fir_par_lane.sv
// fir_par_lane: one output lane; ports clk/rst, x taps (x_k = x[n-k]), b coefs, y saturated result, clamp flag (2-cycle pipeline)
module fir_par_lane
  import fir_par_pkg::*;
#(
  parameter int NB = NB_DEF,
  parameter int N = N_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [(N+1)*NB-1:0]   x,
  input  logic [(N+1)*NB-1:0]   b,
  output logic [NB-1:0]         y,
  output logic                  clamp
);
  localparam int AW = acc_width(NB, N);
  localparam logic signed [AW-1:0] HI = AW'(sat_max(NB));
  localparam logic signed [AW-1:0] LO = AW'(sat_min(NB));
  logic signed [2*NB-1:0] prod [N+1];
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sh;
  logic [NB-1:0] y_n;
  logic clamp_n;
  // products are registered here so coefficients are sampled on the accept edge
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int k = 0; k <= N; k++) prod[k] <= '0;
    else for (int k = 0; k <= N; k++) prod[k] <= $signed(x[k*NB +: NB]) * $signed(b[k*NB +: NB]);
  always_comb begin
    acc = '0;
    for (int k = 0; k <= N; k++) acc = acc + AW'(prod[k]);
    sh = acc >>> (NB - 1);
    clamp_n = sh > HI || sh < LO;
    y_n = sh > HI ? HI[NB-1:0] : sh < LO ? LO[NB-1:0] : sh[NB-1:0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      y <= '0;
      clamp <= 1'b0;
    end else begin
      y <= y_n;
      clamp <= clamp_n;
    end
endmodule

// File: rtl/fir_par.sv
// fir_par: J-parallel FIR, N+1 taps; DIN/VIN in, B/B_LOAD coefficients, DOUT/VOUT/OVF out 2 edges after accept
module fir_par
  import fir_par_pkg::*;
#(
  parameter int NB = NB_DEF,
  parameter int N = N_DEF,
  parameter int J = J_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [J*NB-1:0]     DIN,
  input  logic                VIN,
  input  logic [(N+1)*NB-1:0] B,
  input  logic                B_LOAD,
  output logic [J*NB-1:0]     DOUT,
  output logic                VOUT,
  output logic                OVF
);
  logic [N*NB-1:0] hist;
  logic [(N+1)*NB-1:0] coef;
  logic [(N+J)*NB-1:0] ext;
  logic [J*NB-1:0] ys;
  logic [J-1:0] cl;
  logic v1, v2;
  // sample stream oldest-first: history then the incoming block
  assign ext = {DIN, hist};
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      hist <= '0;
      coef <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      VOUT <= 1'b0;
      OVF <= 1'b0;
      DOUT <= '0;
    end else begin
      if (VIN) hist <= ext[(N+J)*NB-1 -: N*NB];
      if (B_LOAD) coef <= B;
      v1 <= VIN;
      v2 <= v1;
      VOUT <= v2;
      OVF <= v2 & |cl;
      if (v2) DOUT <= ys;
    end
  for (genvar i = 0; i < J; i++) begin : g_lane
    logic [(N+1)*NB-1:0] taps;
    for (genvar k = 0; k <= N; k++) begin : g_tap
      assign taps[k*NB +: NB] = ext[(N+i-k)*NB +: NB];
    end
    fir_par_lane #(.NB(NB), .N(N)) u_lane (
      .clk(CLK),
      .rst(RST),
      .x(taps),
      .b(coef),
      .y(ys[i*NB +: NB]),
      .clamp(cl[i])
    );
  end
endmodule

// File: tb/tb_fir_par.sv
// tb_fir_par: directed and model-checked bench for fir_par (NB=14, N=10, J=3)
module tb_fir_par;
  localparam int NB = 14;
  localparam int N = 10;
  localparam int J = 3;
  typedef logic [J*NB:0] obs_t;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [J*NB-1:0] DIN = '0;
  logic VIN = 1'b0;
  logic [(N+1)*NB-1:0] B = '0;
  logic B_LOAD = 1'b0;
  logic [J*NB-1:0] DOUT;
  logic VOUT;
  logic OVF;
  int n_cmp = 0;
  int n_err = 0;
  obs_t got[$];
  obs_t exp_q[$];
  obs_t last[$];
  obs_t run_a[$];
  int xs[$];
  int mcoef[N+1];
  fir_par #(.NB(NB), .N(N), .J(J)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .VIN(VIN), .B(B), .B_LOAD(B_LOAD),
    .DOUT(DOUT), .VOUT(VOUT), .OVF(OVF)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) if (VOUT) got.push_back({OVF, DOUT});
  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask
  function automatic int rnd();
    return int'($urandom_range(16383)) - 8192;
  endfunction
  function automatic obs_t mk(input int a, input int b, input int c, input bit o);
    obs_t r;
    r[NB-1:0] = NB'(a);
    r[2*NB-1:NB] = NB'(b);
    r[3*NB-1:2*NB] = NB'(c);
    r[J*NB] = o;
    return r;
  endfunction
  // straightforward convolution over the full sample stream since reset
  function automatic obs_t model(input int blk[J]);
    obs_t r;
    longint acc, y;
    int n;
    r = '0;
    for (int j = 0; j < J; j++) xs.push_back(blk[j]);
    for (int j = 0; j < J; j++) begin
      n = xs.size() - J + j;
      acc = 0;
      for (int k = 0; k <= N; k++) if (n - k >= 0) acc += longint'(mcoef[k]) * longint'(xs[n-k]);
      y = acc >>> (NB - 1);
      if (y > 8191) begin y = 8191; r[J*NB] = 1'b1; end
      else if (y < -8192) begin y = -8192; r[J*NB] = 1'b1; end
      r[j*NB +: NB] = y[NB-1:0];
    end
    return r;
  endfunction
  task automatic model_reset();
    xs.delete();
    for (int k = 0; k <= N; k++) mcoef[k] = 0;
    got.delete();
    exp_q.delete();
  endtask
  task automatic send(input int blk[J], input bit v, input bit ld, input int nc[N+1]);
    for (int j = 0; j < J; j++) DIN[j*NB +: NB] = NB'(blk[j]);
    VIN = v;
    B_LOAD = ld;
    if (ld) for (int k = 0; k <= N; k++) B[k*NB +: NB] = NB'(nc[k]);
    @(posedge CLK);
    if (v) exp_q.push_back(model(blk));
    if (ld) mcoef = nc;
    #1;
    VIN = 1'b0;
    B_LOAD = 1'b0;
  endtask
  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge CLK);
      #1;
    end
  endtask
  task automatic load(input int nc[N+1]);
    int z[J] = '{default: 0};
    send(z, 1'b0, 1'b1, nc);
  endtask
  task automatic do_reset();
    RST = 1'b1;
    #2;
    model_reset();
    RST = 1'b0;
  endtask
  task automatic drain(input string tag);
    obs_t g;
    idle(4);
    check($sformatf("%s_cnt", tag), 64'(got.size()), 64'(exp_q.size()));
    last.delete();
    while (got.size() > 0 && exp_q.size() > 0) begin
      g = got.pop_front();
      last.push_back(g);
      check(tag, g, exp_q.pop_front());
    end
    got.delete();
    exp_q.delete();
  endtask
  task automatic impulse(input string tag);
    int nc[N+1];
    int z[J] = '{default: 0};
    int imp[J] = '{8191, 0, 0};
    obs_t tbl[5];
    for (int k = 0; k <= N; k++) nc[k] = 2048;
    tbl[0] = mk(2047, 2047, 2047, 0);
    tbl[1] = mk(2047, 2047, 2047, 0);
    tbl[2] = mk(2047, 2047, 2047, 0);
    tbl[3] = mk(2047, 2047, 0, 0);
    tbl[4] = mk(0, 0, 0, 0);
    load(nc);
    send(imp, 1'b1, 1'b0, nc);
    check($sformatf("%s_lat0", tag), 64'(VOUT), 64'd0);
    @(posedge CLK); #1;
    check($sformatf("%s_lat1", tag), 64'(VOUT), 64'd0);
    @(posedge CLK); #1;
    check($sformatf("%s_lat2", tag), 64'(VOUT), 64'd1);
    check($sformatf("%s_first", tag), 64'({OVF, DOUT}), 64'(tbl[0]));
    repeat (4) send(z, 1'b1, 1'b0, nc);
    idle(4);
    check($sformatf("%s_cnt", tag), 64'(got.size()), 64'd5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      check($sformatf("%s_y%0d", tag, i), 64'(got[i]), 64'(tbl[i]));
    got.delete();
    exp_q.delete();
  endtask
  initial begin
    int nc[N+1];
    int nc2[N+1];
    int blk[J];
    int rb[30][J];
    #2;
    check("rst_vout", 64'(VOUT), 64'd0);
    check("rst_ovf", 64'(OVF), 64'd0);
    check("rst_dout", 64'(DOUT), 64'd0);
    @(negedge CLK);
    model_reset();
    RST = 1'b0;
    impulse("imp");
    do_reset();
    for (int k = 0; k <= N; k++) nc[k] = 4096;
    load(nc);
    for (int j = 0; j < J; j++) blk[j] = 8191;
    repeat (4) send(blk, 1'b1, 1'b0, nc);
    for (int j = 0; j < J; j++) blk[j] = -8192;
    repeat (4) send(blk, 1'b1, 1'b0, nc);
    idle(4);
    if (got.size() >= 8) begin
      check("sat_pos", 64'(got[3]), 64'(mk(8191, 8191, 8191, 1)));
      check("sat_neg", 64'(got[7]), 64'(mk(-8192, -8192, -8192, 1)));
    end else check("sat_len", 64'(got.size()), 64'd8);
    drain("sat");
    for (int k = 0; k <= N; k++) nc[k] = rnd();
    for (int i = 0; i < 30; i++) for (int j = 0; j < J; j++) rb[i][j] = rnd();
    do_reset();
    load(nc);
    for (int i = 0; i < 30; i++) send(rb[i], 1'b1, 1'b0, nc);
    drain("gapless");
    run_a = last;
    do_reset();
    load(nc);
    for (int i = 0; i < 30; i++) begin
      idle(int'($urandom_range(2)));
      send(rb[i], 1'b1, 1'b0, nc);
    end
    drain("gappy");
    check("gap_cnt", 64'(last.size()), 64'd30);
    for (int i = 0; i < 30 && i < last.size() && i < run_a.size(); i++)
      check($sformatf("gap_eq%0d", i), 64'(last[i]), 64'(run_a[i]));
    do_reset();
    for (int k = 0; k <= N; k++) begin nc[k] = rnd(); nc2[k] = rnd(); end
    load(nc);
    for (int k = 0; k <= N; k++) B[k*NB +: NB] = NB'(rnd());
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < J; j++) blk[j] = rnd();
      send(blk, 1'b1, i == 5, nc2);
    end
    drain("bload");
    do_reset();
    for (int k = 0; k <= N; k++) nc[k] = 2048;
    load(nc);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < J; j++) blk[j] = rnd();
      send(blk, 1'b1, 1'b0, nc);
    end
    check("pre_vout", 64'(VOUT), 64'd1);
    #2;
    RST = 1'b1;
    #1;
    check("arst_vout", 64'(VOUT), 64'd0);
    check("arst_dout", 64'(DOUT), 64'd0);
    check("arst_ovf", 64'(OVF), 64'd0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    idle(5);
    check("stale_vout", 64'(got.size()), 64'd0);
    got.delete();
    impulse("rimp");
    do_reset();
    for (int k = 0; k <= N; k++) nc[k] = rnd();
    load(nc);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(9) == 0) idle(1);
      for (int j = 0; j < J; j++) blk[j] = rnd();
      if ($urandom_range(99) == 0) begin
        for (int k = 0; k <= N; k++) nc[k] = rnd();
        send(blk, 1'b1, 1'b1, nc);
      end else send(blk, 1'b1, 1'b0, nc);
    end
    drain("rand");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fir_par.md
FIR_PAR -- requirements
Module: fir_par

Interface
REQ-001 Parameter NB, default 14, signed two's-complement sample and coefficient width.
REQ-002 Parameter N, default 10, filter order (N+1 taps).
REQ-003 Parameter J, default 3, parallelism: samples accepted and produced per clock (J >= 1).
REQ-004 Port CLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port RST  in  1  reset, asynchronous, active-high.
REQ-006 Port DIN  in  J*NB  input block; lane i at bits [(i+1)*NB-1 : i*NB], lane 0 = oldest sample.
REQ-007 Port VIN  in  1  DIN valid; block accepted on a rising edge with VIN=1.
REQ-008 Port B  in  (N+1)*NB  coefficients; b_k at bits [(k+1)*NB-1 : k*NB].
REQ-009 Port B_LOAD  in  1  capture B into the internal coefficient register on this edge.
REQ-010 Port DOUT  out  J*NB  output block, same lane ordering as DIN.
REQ-011 Port VOUT  out  1  DOUT valid, one cycle per accepted block.
REQ-012 Port OVF  out  1  qualified by VOUT: at least one lane of DOUT saturated.

Function
REQ-013 Lane i of the block accepted at step m SHALL be y[mJ+i] = sum_{k=0..N} b_k * x[mJ+i-k]; samples before the first accepted block after reset count as 0.
REQ-014 Samples and coefficients SHALL be interpreted as Q1.(NB-1); products held at full 2*NB bits; accumulation at 2*NB + ceil(log2(N+1)) bits with no intermediate loss.
REQ-015 Each output lane SHALL be the accumulator arithmetically shifted right by NB-1 (floor), then saturated to [-2^(NB-1), 2^(NB-1)-1].
REQ-016 OVF SHALL be 1 in the VOUT cycle when any lane clamped in REQ-015, else 0; OVF SHALL be 0 whenever VOUT=0.
REQ-017 Latency SHALL be exactly 2 cycles: a block accepted at edge t produces VOUT=1 and its DOUT after edge t+2.
REQ-018 The sample history (last N samples) SHALL advance by J samples only on edges with VIN=1; VIN=0 SHALL leave it unchanged, so gaps in VIN do not alter results.
REQ-019 The pipeline SHALL advance every cycle; VOUT SHALL be VIN delayed by 2 cycles; DOUT SHALL hold its last value while VOUT=0.
REQ-020 When J > N+1 or J <= N+1, the same equations SHALL hold (history depth N independent of J).
REQ-021 B_LOAD=1 SHALL update the coefficient register; a block accepted on the same edge as B_LOAD SHALL use the old coefficients, the next block the new ones.
REQ-022 B SHALL be ignored on edges with B_LOAD=0.

Reset
REQ-023 While RST=1: VOUT=0, OVF=0, DOUT=0, sample history=0, coefficient register=0, pipeline valid bits=0, immediately and independent of CLK.
REQ-024 RST asserted mid-stream SHALL discard all in-flight blocks; no VOUT pulse for blocks accepted before reset SHALL appear after release.
REQ-025 First edge after RST deassertion SHALL be able to accept a block and load coefficients.

Structure
REQ-026 Package fir_par_pkg SHALL hold default NB/N/J and the accumulator-width and saturation-bound constants/functions.
REQ-027 Sub-module fir_par_lane SHALL compute one output lane (tap products, sum, shift, saturate, clamp flag); fir_par SHALL instantiate J of them plus shared history, coefficient and valid-pipeline registers.

Verification (NB=14, N=10, J=3)
REQ-028 All b_k=2048 (0.25), single sample 8191 in lane 0 of block 0, zeros after -> y[0..10]=2047, y[11..]=0, OVF=0, first VOUT 2 cycles after accept.
REQ-029 All b_k=4096, every input 8191 -> every lane 8191, OVF=1; every input -8192 -> every lane -8192, OVF=1.
REQ-030 Same random 30-block stream sent gapless and with random VIN gaps -> identical DOUT sequences, VOUT pulse count 30 in both.
REQ-031 B_LOAD with new coefficients on the same edge as block 5 -> block 5 matches old-coefficient model, block 6 onward new-coefficient model.
REQ-032 RST pulse 1 cycle after accepting a block -> VOUT, DOUT, OVF drop to 0 asynchronously; no stale VOUT after release; next impulse reproduces REQ-028 from zero history after coefficients reloaded.
REQ-033 Random coefficients/data over 1000 blocks -> bit-exact against reference model per REQ-013..REQ-016.
